// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, 8-bit ALU with carry/zero flags, branch
// resolution, and the EXE/MEM pipeline register.
module exe_stage #(
    parameter int DW = 8,
    parameter int RW = 3,
    parameter int PW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          regWr_IN,
    input  logic          memRd_IN,
    input  logic          memWr_IN,
    input  logic          cWr_IN,
    input  logic          zWr_IN,
    input  logic          immConst_IN,
    input  logic [3:0]    aluOp_IN,
    input  logic [4:0]    opCode_IN,
    input  logic [RW-1:0] rd_IN,
    input  logic [RW-1:0] rs_IN,
    input  logic [RW-1:0] rt_IN,
    input  logic [DW-1:0] regData1_IN,
    input  logic [DW-1:0] regData2_IN,
    input  logic [DW-1:0] brDisp_IN,
    input  logic [PW-1:0] pcPlus1_IN,
    input  logic          wbRegWr_IN,
    input  logic [RW-1:0] wbRd_IN,
    input  logic [DW-1:0] wbData_IN,
    output logic          regWr_OUT,
    output logic          memRd_OUT,
    output logic          memWr_OUT,
    output logic [RW-1:0] rd_OUT,
    output logic [DW-1:0] aluRes_OUT,
    output logic [DW-1:0] storeData_OUT,
    output logic          carry_OUT,
    output logic          zero_OUT,
    output logic          brTaken_OUT,
    output logic [PW-1:0] brTarget_OUT
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_ADDC  = 4'd1,
        ALU_SUB   = 4'd2,
        ALU_SUBC  = 4'd3,
        ALU_AND   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_XOR   = 4'd6,
        ALU_NOT   = 4'd7,
        ALU_SHL   = 4'd8,
        ALU_SHR   = 4'd9,
        ALU_ROL   = 4'd10,
        ALU_ROR   = 4'd11,
        ALU_PASSB = 4'd12
    } alu_op_e;

    localparam logic [4:0] OP_BZ  = 5'b10100;
    localparam logic [4:0] OP_BNZ = 5'b10101;
    localparam logic [4:0] OP_BC  = 5'b10110;
    localparam logic [4:0] OP_BNC = 5'b10111;
    localparam logic [4:0] OP_JMP = 5'b11000;

    logic [DW-1:0] op_a;
    logic [DW-1:0] fwd_b;
    logic [DW-1:0] op_b;
    logic [DW:0]   alu_wide;
    logic [DW-1:0] alu_res;
    logic          alu_cout;

    // EXE/MEM wins over WB: it holds the younger producer of the register.
    assign op_a = (regWr_OUT  && rd_OUT  == rs_IN) ? aluRes_OUT :
                  (wbRegWr_IN && wbRd_IN == rs_IN) ? wbData_IN  : regData1_IN;
    assign fwd_b = (regWr_OUT  && rd_OUT  == rt_IN) ? aluRes_OUT :
                   (wbRegWr_IN && wbRd_IN == rt_IN) ? wbData_IN  : regData2_IN;
    assign op_b  = immConst_IN ? brDisp_IN : fwd_b;

    // Bit DW of the wide result is the new carry for every operation,
    // including borrow on subtract and the bit shifted or rotated out.
    always_comb begin
        // NOTE: default first so every path assigns alu_wide and no latch is inferred.
        alu_wide = '0;
        case (aluOp_IN)
            ALU_ADD:   alu_wide = {1'b0, op_a} + {1'b0, op_b};
            ALU_ADDC:  alu_wide = {1'b0, op_a} + {1'b0, op_b} + {{DW{1'b0}}, carry_OUT};
            ALU_SUB:   alu_wide = {1'b0, op_a} - {1'b0, op_b};
            ALU_SUBC:  alu_wide = {1'b0, op_a} - {1'b0, op_b} - {{DW{1'b0}}, carry_OUT};
            ALU_AND:   alu_wide = {1'b0, op_a & op_b};
            ALU_OR:    alu_wide = {1'b0, op_a | op_b};
            ALU_XOR:   alu_wide = {1'b0, op_a ^ op_b};
            ALU_NOT:   alu_wide = {1'b0, ~op_a};
            ALU_SHL:   alu_wide = {op_a, 1'b0};
            ALU_SHR:   alu_wide = {op_a[0], 1'b0, op_a[DW-1:1]};
            ALU_ROL:   alu_wide = {op_a[DW-1], op_a[DW-2:0], op_a[DW-1]};
            ALU_ROR:   alu_wide = {op_a[0], op_a[0], op_a[DW-1:1]};
            ALU_PASSB: alu_wide = {1'b0, op_b};
            default:   alu_wide = {1'b0, op_a};
        endcase
    end

    assign alu_res  = alu_wide[DW-1:0];
    assign alu_cout = alu_wide[DW];

    // Branches see only flags committed by earlier instructions, never this cycle's ALU.
    always_comb begin
        brTaken_OUT = 1'b0;
        case (opCode_IN)
            OP_BZ:   brTaken_OUT = zero_OUT;
            OP_BNZ:  brTaken_OUT = ~zero_OUT;
            OP_BC:   brTaken_OUT = carry_OUT;
            OP_BNC:  brTaken_OUT = ~carry_OUT;
            OP_JMP:  brTaken_OUT = 1'b1;
            default: brTaken_OUT = 1'b0;
        endcase
    end

    assign brTarget_OUT = pcPlus1_IN + {{(PW-DW){brDisp_IN[DW-1]}}, brDisp_IN};

    // NOTE: every pipeline register is cleared by reset so a bubble, not a stale instruction, leaves reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWr_OUT     <= 1'b0;
            memRd_OUT     <= 1'b0;
            memWr_OUT     <= 1'b0;
            rd_OUT        <= '0;
            aluRes_OUT    <= '0;
            storeData_OUT <= '0;
        end else begin
            // NOTE: non-blocking so all registers sample pre-edge values.
            regWr_OUT     <= regWr_IN;
            memRd_OUT     <= memRd_IN;
            memWr_OUT     <= memWr_IN;
            rd_OUT        <= rd_IN;
            aluRes_OUT    <= alu_res;
            storeData_OUT <= fwd_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_OUT <= 1'b0;
            zero_OUT  <= 1'b0;
        end else begin
            if (cWr_IN) carry_OUT <= alu_cout;
            if (zWr_IN) zero_OUT  <= (alu_res == '0);
        end
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage that consumes the ID/EXE pipeline register outputs.
- Performs operand forwarding, 8-bit ALU operation, carry/zero flag update and branch resolution.
- Drives the EXE/MEM pipeline register held inside this block.
- Branch taken/target go combinationally to PC/fetch logic and the flush network.

Parameters:
- DW, 8, datapath width.
- RW, 3, register index width (8 registers, R0 is an ordinary register).
- PW, 12, program counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN, immConst_IN  in  1 each  control from ID/EXE.
- aluOp_IN  in  4  ALU operation.
- opCode_IN  in  5  instruction opcode.
- rd_IN, rs_IN, rt_IN  in  RW  register indices.
- regData1_IN, regData2_IN  in  DW  register file read data.
- brDisp_IN  in  DW  immediate / branch displacement.
- pcPlus1_IN  in  PW  PC+1 of this instruction.
- wbRegWr_IN  in  1  WB-stage write enable.
- wbRd_IN  in  RW  WB destination.
- wbData_IN  in  DW  WB write data.
- regWr_OUT, memRd_OUT, memWr_OUT  out  1  registered EXE/MEM control.
- rd_OUT  out  RW  registered destination.
- aluRes_OUT  out  DW  registered ALU result / memory address.
- storeData_OUT  out  DW  registered forwarded rt data.
- carry_OUT, zero_OUT  out  1  flag registers.
- brTaken_OUT  out  1  combinational branch taken (flushes IF/ID and ID/EXE).
- brTarget_OUT  out  PW  combinational branch target.

Behaviour:
- Reset (async, rst=1): all registered outputs (regWr, memRd, memWr, rd, aluRes, storeData, carry, zero) = 0 immediately. Reset mid-operation discards the in-flight instruction.
- Forwarding for operand A (rs), evaluated in the same order for rt:
  - if regWr_OUT && rd_OUT==rs → aluRes_OUT;
  - else if wbRegWr_IN && wbRd_IN==rs → wbData_IN;
  - else regData1_IN.
  - The EXE/MEM source has priority when both match.
  - Load-use hazards are stalled upstream; this block does not forward load data from EXE/MEM.
- Operand B: immConst_IN ? brDisp_IN : forwarded rt. storeData always takes forwarded rt.
- ALU operations (9-bit internal; res is the low 8 bits, cout is the new carry):
  - 0 ADD: A+B, cout = bit 8.
  - 1 ADDC: A+B+C, cout = bit 8.
  - 2 SUB: A−B, cout = 1 if A<B unsigned (borrow).
  - 3 SUBC: A−B−C, cout = borrow.
  - 4 AND, 5 OR, 6 XOR: cout = 0.
  - 7 NOT A: cout = 0.
  - 8 SHL A: cout = A[7].
  - 9 SHR A (logical): cout = A[0].
  - 10 ROL A, 11 ROR A: cout = bit rotated out.
  - 12 PASSB: cout = 0.
  - 13–15 PASSA: cout = 0.
  - Result wraps mod 256.
- Flags: on posedge, carry ← cout if cWr_IN, zero ← (res==0) if zWr_IN; otherwise hold. Both may update in the same cycle.
- Branch resolution:
  - Uses current flag registers, i.e. values written by earlier instructions; the flag update of a preceding instruction is visible the next cycle with no bypass.
  - Opcodes: 5'b10100 BZ (zero=1), 5'b10101 BNZ (zero=0), 5'b10110 BC (carry=1), 5'b10111 BNC (carry=0), 5'b11000 JMP (always).
  - Target = pcPlus1_IN + sign-extended brDisp_IN, mod 2^12.
  - brTaken_OUT = 0 for all other opcodes. brTarget_OUT is always driven.
- EXE/MEM register: on every posedge (no enable), captures regWr/memRd/memWr/rd/res/storeData. Latency 1 cycle. A bubble (all control 0) propagates as all-zero control.

Test Plan:
- Reset asserted mid-cycle with aluRes_OUT=8'h5A → all outputs 0 before the next clk edge; flags 0.
- ADD rs=8'hF0, rt=8'h20, cWr=zWr=1 → next cycle aluRes_OUT=8'h10, carry=1, zero=0; following ADDC 8'h01+8'h01 → 8'h03.
- SUB 8'h33−8'h33, zWr=1, then BZ opcode 5'b10100, pcPlus1=12'h0FF, brDisp=8'hFE → brTaken=1, brTarget=12'h0FD.
- Back-to-back dependency: ADD r1 ← 8'h05+8'h03, then ADD r2 ← r1+r1 with stale regData1=0 → aluRes_OUT=8'h10 (EXE/MEM forward). With both WB and EXE/MEM matching rs, EXE/MEM value is selected.
- JMP pcPlus1=12'hFFF, brDisp=8'h02 → brTarget=12'h001 (wrap); non-branch opcode → brTaken=0; flags unchanged when cWr=zWr=0.
- SHL 8'h81 with cWr=1 → aluRes_OUT=8'h02, carry=1; ROR 8'h01 → 8'h80, carry=1; PASSB with immConst=1, brDisp=8'h7C → 8'h7C.
